// File: rtl/valid_delay_pipe.sv
// Delay line for a valid-qualified data bus: DEPTH register stages with stall, flush,
// occupancy count and a registered pulse for inputs that were not accepted.
module valid_delay_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_datavalid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_datavalid,
  output logic [CNT_W-1:0]  occupancy,
  output logic              empty,
  output logic              in_dropped
);

  // Index 0 is the entry stage, index DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0]             occ_q, occ_d;
  logic                         drop_q, drop_d;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    occ_d  = occ_q;
    drop_d = 1'b0;
    if (flush) begin
      vld_d  = '0;
      dat_d  = '0;
      occ_d  = '0;
      drop_d = in_datavalid;
    end else if (stall) begin
      drop_d = in_datavalid;
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
      vld_d[0] = in_datavalid;
      dat_d[0] = in_datavalid ? in_data : '0;
      // Incoming valid and departing last-stage valid can never push the count past 0..DEPTH.
      occ_d = occ_q + CNT_W'(in_datavalid) - CNT_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      dat_q  <= '0;
      occ_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  assign out_data      = dat_q[DEPTH-1];
  assign out_datavalid = vld_q[DEPTH-1];
  assign occupancy     = occ_q;
  assign empty         = (occ_q == '0);
  assign in_dropped    = drop_q;

endmodule

// File: tb/tb_valid_delay_pipe.sv
// Bench for valid_delay_pipe: vector table with a latency-tracking scoreboard for the default
// 8-bit/7-stage instance, plus a hand-written sequence for a 16-bit single-stage instance.
module tb_valid_delay_pipe;

  localparam int Depth = 7;

  logic       clk = 1'b0;
  logic       rst, flush, stall, in_v;
  logic [7:0] in_d, out_d;
  logic       out_v, empty, dropped;
  logic [2:0] occ;

  logic        rst1, flush1, stall1, in_v1;
  logic [15:0] in_d1, out_d1;
  logic        out_v1, empty1, dropped1;
  logic [0:0]  occ1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  valid_delay_pipe #(.DATA_W(8), .DEPTH(Depth)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_d),
    .in_datavalid (in_v),
    .stall        (stall),
    .flush        (flush),
    .out_data     (out_d),
    .out_datavalid(out_v),
    .occupancy    (occ),
    .empty        (empty),
    .in_dropped   (dropped)
  );

  valid_delay_pipe #(.DATA_W(16), .DEPTH(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst1),
    .in_data      (in_d1),
    .in_datavalid (in_v1),
    .stall        (stall1),
    .flush        (flush1),
    .out_data     (out_d1),
    .out_datavalid(out_v1),
    .occupancy    (occ1),
    .empty        (empty1),
    .in_dropped   (dropped1)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       stall;
    logic       v;
    logic [7:0] d;
    logic       exp_drop;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         due;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic s, input logic v,
                     input logic [7:0] d, input logic drop);
    vec_t e;
    e.rst = r; e.flush = f; e.stall = s; e.v = v; e.d = d; e.exp_drop = drop;
    vecs.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   shifts;
    logic exp_v;
    int   exp_d;

    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_v = 1'b0; in_d = '0;
    rst1 = 1'b1; flush1 = 1'b0; stall1 = 1'b0; in_v1 = 1'b0; in_d1 = '0;

    // 1: reset, stream 0x11..0x17, drain
    add(1, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 8'h11 + 8'(i), 0);
    idle(10);
    // 2: data with valid low must not appear
    add(0, 0, 0, 0, 8'hAB, 0);
    idle(8);
    // 3: stall with 0x21 mid-pipe and valid input offered
    add(0, 0, 0, 1, 8'h21, 0);
    add(0, 0, 0, 1, 8'h22, 0);
    add(0, 0, 0, 1, 8'h23, 0);
    idle(1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 8'hEE, 1);
    idle(10);
    // stall with pipe full
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 8'h61 + 8'(i), 0);
    add(0, 0, 1, 1, 8'hFF, 1);
    add(0, 0, 1, 1, 8'hFE, 1);
    idle(10);
    // 4: fill to 5 then flush and stall together
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 8'h41 + 8'(i), 0);
    add(0, 1, 1, 1, 8'h99, 1);
    idle(8);
    // 5: reset mid-stream at occupancy 4
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 8'h51 + 8'(i), 0);
    add(1, 0, 0, 1, 8'h77, 0);
    add(0, 0, 0, 1, 8'h5A, 0);
    idle(9);

    shifts = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      in_v = vecs[i].v; in_d = vecs[i].d;
      @(posedge clk);
      if (vecs[i].rst || vecs[i].flush) begin
        sb.delete();
      end else if (!vecs[i].stall) begin
        shifts++;
        if (vecs[i].v) sb.push_back('{d: vecs[i].d, due: shifts + Depth - 1});
      end
      #1;
      while (sb.size() > 0 && sb[0].due < shifts) void'(sb.pop_front());
      exp_v = (sb.size() > 0 && sb[0].due == shifts);
      exp_d = exp_v ? int'(sb[0].d) : 0;
      check($sformatf("v%0d out_datavalid", i), int'(out_v), int'(exp_v));
      check($sformatf("v%0d out_data", i), int'(out_d), exp_d);
      check($sformatf("v%0d occupancy", i), int'(occ), sb.size());
      check($sformatf("v%0d empty", i), int'(empty), int'(sb.size() == 0));
      check($sformatf("v%0d in_dropped", i), int'(dropped), int'(vecs[i].exp_drop));
    end
    rst = 1'b0; in_v = 1'b0; stall = 1'b0; flush = 1'b0;

    // 6: DEPTH=1, DATA_W=16
    step1();
    check("d1 reset occupancy", int'(occ1), 0);
    check("d1 reset valid", int'(out_v1), 0);
    rst1 = 1'b0; in_v1 = 1'b1; in_d1 = 16'hBEEF;
    step1();
    check("d1 beef data", int'(out_d1), 16'hBEEF);
    check("d1 beef valid", int'(out_v1), 1);
    check("d1 beef occupancy", int'(occ1), 1);
    check("d1 beef empty", int'(empty1), 0);
    in_v1 = 1'b0; in_d1 = 16'h1111;
    step1();
    check("d1 idle data", int'(out_d1), 0);
    check("d1 idle valid", int'(out_v1), 0);
    check("d1 idle occupancy", int'(occ1), 0);
    check("d1 idle empty", int'(empty1), 1);
    in_v1 = 1'b1; in_d1 = 16'h1234;
    step1();
    check("d1 load data", int'(out_d1), 16'h1234);
    stall1 = 1'b1; in_d1 = 16'h5555;
    step1();
    check("d1 stall data", int'(out_d1), 16'h1234);
    check("d1 stall valid", int'(out_v1), 1);
    check("d1 stall occupancy", int'(occ1), 1);
    check("d1 stall dropped", int'(dropped1), 1);
    stall1 = 1'b0; in_v1 = 1'b0;
    step1();
    check("d1 drain valid", int'(out_v1), 0);
    check("d1 drain occupancy", int'(occ1), 0);
    check("d1 drain dropped", int'(dropped1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
